// File: rtl/rst_req_gen_pkg.sv
// Shared definitions for the debug-side reset request generator.
//  - rrg_state_t : FSM state encodings (3 bits)
//  - JTAG_RESET_FF_LEVELS : synchroniser depth of the companion reset controller
//  - RRG_* : default parameter values for rst_req_gen
package rst_req_gen_pkg;

    typedef enum logic [2:0] {
        RRG_IDLE      = 3'd0,
        RRG_ASSERT    = 3'd1,
        RRG_WAIT_HIGH = 3'd2,
        RRG_SETTLE    = 3'd3,
        RRG_ACK       = 3'd4,
        RRG_ERR       = 3'd5
    } rrg_state_t;

    localparam int unsigned JTAG_RESET_FF_LEVELS = 5;

    localparam int unsigned RRG_HOLD_CYCLES   = 4;
    localparam int unsigned RRG_SETTLE_CYCLES = 8;
    localparam int unsigned RRG_TMO_CYCLES    = 256;
    localparam int unsigned RRG_TMR_W         = 16;
    localparam int unsigned RRG_CNT_W         = 8;

endpackage

// File: rtl/rst_req_gen.sv
// Debug-side initiator for the core reset path.
// Turns a 4-phase req/ack from the debug module into a timed rst_jtag pulse,
// then watches the core_rst_n returned by the reset controller: the core must
// be seen in reset and then stably out of reset before the request is acked.
// If it never comes back (or never went down) the sequence ends in an error
// state that acks with a sticky timeout flag.
//
// Ports
//  clk          in   clock
//  rst_n        in   synchronous active-low reset
//  req_i        in   reset request level from the debug module (4-phase)
//  core_rst_n_i in   core_rst_n fed back from the reset controller
//  rst_jtag_o   out  active-high reset request to the reset controller
//  ack_o        out  handshake ack, held until req_i drops
//  busy_o       out  high in every state except IDLE
//  timeout_o    out  sticky failure flag, cleared when the next request is accepted
//  rst_cnt_o    out  saturating count of accepted requests
module rst_req_gen
    import rst_req_gen_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = RRG_HOLD_CYCLES,
    parameter int unsigned SETTLE_CYCLES = RRG_SETTLE_CYCLES,
    parameter int unsigned TMO_CYCLES    = RRG_TMO_CYCLES,
    parameter int unsigned TMR_W         = RRG_TMR_W,
    parameter int unsigned CNT_W         = RRG_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             core_rst_n_i,
    output logic             rst_jtag_o,
    output logic             ack_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] rst_cnt_o
);

    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD    = TMR_W'(TMO_CYCLES - 1);

    rrg_state_t       state;
    rrg_state_t       state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             seen_low;
    logic             seen_low_nxt;
    logic             accept;
    logic             fail;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (&val) ? val : val + CNT_W'(1);
    endfunction

    // Next-state logic. One down-counter serves the HOLD, TMO and SETTLE
    // phases; each phase loads it on entry, so it never needs a reset.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        seen_low_nxt = seen_low;
        accept       = 1'b0;
        fail         = 1'b0;

        case (state)
            RRG_IDLE: begin
                if (req_i) begin
                    state_nxt    = RRG_ASSERT;
                    timer_nxt    = HOLD_LOAD;
                    seen_low_nxt = 1'b0;
                    accept       = 1'b1;
                end
            end

            RRG_ASSERT: begin
                if (!core_rst_n_i) begin
                    seen_low_nxt = 1'b1;
                end
                if (timer == '0) begin
                    // The low may arrive in the very last hold cycle, so the
                    // current input is considered alongside the stored flag.
                    if (seen_low || !core_rst_n_i) begin
                        state_nxt = RRG_WAIT_HIGH;
                        timer_nxt = TMO_LOAD;
                    end else begin
                        state_nxt = RRG_ERR;
                        fail      = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            RRG_WAIT_HIGH: begin
                if (core_rst_n_i) begin
                    state_nxt = RRG_SETTLE;
                    timer_nxt = SETTLE_LOAD;
                end else if (timer == '0) begin
                    state_nxt = RRG_ERR;
                    fail      = 1'b1;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            RRG_SETTLE: begin
                // Any dip restarts the wait with a fresh timeout budget.
                if (!core_rst_n_i) begin
                    state_nxt = RRG_WAIT_HIGH;
                    timer_nxt = TMO_LOAD;
                end else if (timer == '0) begin
                    state_nxt = RRG_ACK;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            RRG_ACK, RRG_ERR: begin
                if (!req_i) begin
                    state_nxt = RRG_IDLE;
                end
            end

            default: state_nxt = RRG_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and never see the inputs combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RRG_IDLE;
            rst_jtag_o <= 1'b0;
            ack_o      <= 1'b0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
            rst_cnt_o  <= '0;
        end else begin
            state      <= state_nxt;
            rst_jtag_o <= (state_nxt == RRG_ASSERT);
            ack_o      <= (state_nxt == RRG_ACK) || (state_nxt == RRG_ERR);
            busy_o     <= (state_nxt != RRG_IDLE);
            if (accept) begin
                timeout_o <= 1'b0;
                rst_cnt_o <= sat_inc(rst_cnt_o);
            end else if (fail) begin
                timeout_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        timer    <= timer_nxt;
        seen_low <= seen_low_nxt;
    end

endmodule

// File: tb/tb_rst_req_gen.sv
// Directed bench for rst_req_gen with default parameters.
// core_rst_n_i is driven by hand-written schedules that stand in for the
// reset controller. Cycle c means the interval after the c-th clock edge
// following the request; inputs set in cycle c are sampled at edge c+1.
module tb_rst_req_gen;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       core_n;
    logic       rst_jtag;
    logic       ack;
    logic       busy;
    logic       timeout;
    logic [7:0] rst_cnt;

    int pass_cnt;
    int total_cnt;

    rst_req_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .core_rst_n_i (core_n),
        .rst_jtag_o   (rst_jtag),
        .ack_o        (ack),
        .busy_o       (busy),
        .timeout_o    (timeout),
        .rst_cnt_o    (rst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n  = 1'b0;
        req    = 1'b0;
        core_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        total_cnt++;
        if ({rst_jtag, ack, busy, timeout} !== 4'b0000)
            $display("FAIL reset outputs: got %b want 0000", {rst_jtag, ack, busy, timeout});
        else pass_cnt++;
        total_cnt++;
        if (rst_cnt !== 8'd0)
            $display("FAIL reset rst_cnt: got %0d want 0", rst_cnt);
        else pass_cnt++;
    endtask

    // core low c2..c9, high from c10 -> SETTLE c11..c18 -> ACK c19.
    task automatic test_nominal;
        logic exp;
        do_reset();
        req    = 1'b1;
        core_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            core_n = (c >= 2 && c <= 9) ? 1'b0 : 1'b1;
            exp = (c >= 1 && c <= 4);
            total_cnt++;
            if (rst_jtag !== exp)
                $display("FAIL nominal rst_jtag c%0d: got %b want %b", c, rst_jtag, exp);
            else pass_cnt++;
            exp = (c == 19);
            total_cnt++;
            if (ack !== exp)
                $display("FAIL nominal ack c%0d: got %b want %b", c, ack, exp);
            else pass_cnt++;
            exp = (c <= 19);
            total_cnt++;
            if (busy !== exp)
                $display("FAIL nominal busy c%0d: got %b want %b", c, busy, exp);
            else pass_cnt++;
            if (c == 19) req = 1'b0;
        end
        total_cnt++;
        if (rst_cnt !== 8'd1)
            $display("FAIL nominal rst_cnt: got %0d want 1", rst_cnt);
        else pass_cnt++;
        total_cnt++;
        if (timeout !== 1'b0)
            $display("FAIL nominal timeout: got %b want 0", timeout);
        else pass_cnt++;
    endtask

    // Continues from test_nominal: DUT is in the IDLE cycle right after ACK.
    task automatic test_back_to_back;
        req = 1'b1;
        tick();
        total_cnt++;
        if ({rst_jtag, busy, ack} !== 3'b110)
            $display("FAIL b2b outputs: got %b want 110", {rst_jtag, busy, ack});
        else pass_cnt++;
        total_cnt++;
        if (rst_cnt !== 8'd2)
            $display("FAIL b2b rst_cnt: got %0d want 2", rst_cnt);
        else pass_cnt++;
    endtask

    // ASSERT c1..c4, WAIT_HIGH c5..c260, ERR c261.
    task automatic test_stuck_low;
        logic exp;
        do_reset();
        req    = 1'b1;
        core_n = 1'b0;
        for (int c = 1; c <= 261; c++) begin
            tick();
            exp = (c == 261);
            total_cnt++;
            if (ack !== exp)
                $display("FAIL stuck_low ack c%0d: got %b want %b", c, ack, exp);
            else pass_cnt++;
            total_cnt++;
            if (timeout !== exp)
                $display("FAIL stuck_low timeout c%0d: got %b want %b", c, timeout, exp);
            else pass_cnt++;
        end
        req = 1'b0;
        tick();
        total_cnt++;
        if ({ack, busy, timeout} !== 3'b001)
            $display("FAIL stuck_low idle: got %b want 001", {ack, busy, timeout});
        else pass_cnt++;
        req = 1'b1;
        tick();
        total_cnt++;
        if ({rst_jtag, timeout} !== 2'b10)
            $display("FAIL stuck_low rearm: got %b want 10", {rst_jtag, timeout});
        else pass_cnt++;
        total_cnt++;
        if (rst_cnt !== 8'd2)
            $display("FAIL stuck_low rst_cnt: got %0d want 2", rst_cnt);
        else pass_cnt++;
    endtask

    // core never drops: ASSERT c1..c4, ERR c5.
    task automatic test_never_low;
        logic exp;
        do_reset();
        req    = 1'b1;
        core_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp = (c <= 4);
            total_cnt++;
            if (rst_jtag !== exp)
                $display("FAIL never_low rst_jtag c%0d: got %b want %b", c, rst_jtag, exp);
            else pass_cnt++;
            exp = (c == 5);
            total_cnt++;
            if ({ack, timeout} !== {exp, exp})
                $display("FAIL never_low ack/timeout c%0d: got %b want %b", c, {ack, timeout}, {exp, exp});
            else pass_cnt++;
        end
    endtask

    // Dip in c15 (settle count 3) -> WAIT_HIGH c16 -> SETTLE c17..c24 -> ACK c25.
    task automatic test_glitch;
        logic exp;
        do_reset();
        req    = 1'b1;
        core_n = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            core_n = ((c >= 2 && c <= 9) || c == 15) ? 1'b0 : 1'b1;
            exp = (c == 25);
            total_cnt++;
            if (ack !== exp)
                $display("FAIL glitch ack c%0d: got %b want %b", c, ack, exp);
            else pass_cnt++;
            total_cnt++;
            if (busy !== 1'b1)
                $display("FAIL glitch busy c%0d: got %b want 1", c, busy);
            else pass_cnt++;
        end
        total_cnt++;
        if (timeout !== 1'b0)
            $display("FAIL glitch timeout: got %b want 0", timeout);
        else pass_cnt++;
    endtask

    // req is a 1-cycle pulse; the full sequence still runs, ack for c19 only.
    task automatic test_early_drop;
        logic exp;
        do_reset();
        req    = 1'b1;
        core_n = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            req    = 1'b0;
            core_n = (c >= 2 && c <= 9) ? 1'b0 : 1'b1;
            exp = (c >= 1 && c <= 4);
            total_cnt++;
            if (rst_jtag !== exp)
                $display("FAIL early_drop rst_jtag c%0d: got %b want %b", c, rst_jtag, exp);
            else pass_cnt++;
            exp = (c == 19);
            total_cnt++;
            if (ack !== exp)
                $display("FAIL early_drop ack c%0d: got %b want %b", c, ack, exp);
            else pass_cnt++;
            exp = (c <= 19);
            total_cnt++;
            if (busy !== exp)
                $display("FAIL early_drop busy c%0d: got %b want %b", c, busy, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req    = 1'b1;
        core_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({rst_jtag, busy, rst_cnt} !== {2'b11, 8'd1})
            $display("FAIL reset_mid pre: got %b/%0d want 11/1", {rst_jtag, busy}, rst_cnt);
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if ({rst_jtag, ack, busy, timeout} !== 4'b0000)
            $display("FAIL reset_mid outputs: got %b want 0000", {rst_jtag, ack, busy, timeout});
        else pass_cnt++;
        total_cnt++;
        if (rst_cnt !== 8'd0)
            $display("FAIL reset_mid rst_cnt: got %0d want 0", rst_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        req   = 1'b0;
    endtask

    // Each request with core held high ends in ERR at c5; drop req -> IDLE.
    task automatic test_saturation;
        do_reset();
        core_n = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            req = 1'b1;
            repeat (5) tick();
            req = 1'b0;
            tick();
            if (i == 254 || i == 255) begin
                total_cnt++;
                if (rst_cnt !== 8'(i))
                    $display("FAIL sat rst_cnt at %0d: got %0d want %0d", i, rst_cnt, i);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (rst_cnt !== 8'd255)
            $display("FAIL sat rst_cnt final: got %0d want 255", rst_cnt);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        req       = 1'b0;
        core_n    = 1'b1;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_stuck_low();
        test_never_low();
        test_glitch();
        test_early_drop();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
